// File: rtl/apb3_cmd_requester_pkg.sv
// Shared types for the APB3 command requester: FSM states, the response record
// and the timeout-counter sizing helper.
package apb3_cmd_requester_pkg;

  // Response record is sized for the widest supported data bus; narrower
  // instances cast into and out of it.
  localparam int unsigned RspDataWidth = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb3_state_e;

  typedef struct packed {
    logic [RspDataWidth-1:0] rdata;
    logic                    err;
    logic                    timeout;
  } apb3_rsp_t;

  // A disabled timeout (0 cycles) still needs a 1-bit counter to elaborate.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb3_cmd_requester_timeout_counter.sv
// Saturating ACCESS-cycle counter; flags the cycle in which the limit is reached.
module apb3_timeout_counter #(
  parameter int unsigned Width = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] cnt;
  logic [Width:0]   cnt_inc;

  // expired looks one count ahead so the FSM can leave ACCESS on the same edge
  // that would bring the counter to the limit.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign expired = enable && (limit != '0) && (cnt_inc >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb3_cmd_requester.sv
// APB3 requester: one outstanding command at a time, turned into an APB3
// transfer and returned on a response stream, with a PREADY timeout.
//
// state  | meaning
// IDLE   | ready for a command; APB idle
// SETUP  | PSEL high, PENABLE low
// ACCESS | PSEL and PENABLE high; waiting for PREADY or timeout
// RESP   | response held until rsp_ready_i
module apb3_cmd_requester
  import apb3_cmd_requester_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [AddrWidth-1:0] PADDR,
  output logic [DataWidth-1:0] PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [DataWidth-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam int unsigned          CntWidth = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] Limit    = CntWidth'(TimeoutCycles);

  apb3_state_e state;
  apb3_rsp_t   rsp_q;
  logic        accept;
  logic        expired;

  // Held low during reset so nothing can be accepted while outputs are cleared.
  assign req_ready_o = (state == ST_IDLE) && !RST;
  assign accept      = req_valid_i && req_ready_o;

  apb3_timeout_counter #(
    .Width (CntWidth)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clear   (accept),
    .enable  (state == ST_ACCESS),
    .limit   (Limit),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            PADDR  <= req_addr_i;
            PWRITE <= req_write_i;
            PWDATA <= req_wdata_i;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            rsp_q.rdata   <= PWRITE ? '0 : RspDataWidth'(PRDATA);
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state         <= ST_RESP;
          end else if (expired) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_rdata_o   = DataWidth'(rsp_q.rdata);
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb3_cmd_requester.sv
// Directed bench for apb3_cmd_requester; inputs driven and outputs checked on
// the falling clock edge.
module tb_apb3_cmd_requester;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  int checks = 0;
  int fails  = 0;

  apb3_cmd_requester #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_write_i   (req_write_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for one edge (edge 0); returns in cycle 1.
  task automatic go(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    @(negedge CLK);
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFF0;
    req_wdata_i = 32'h0BAD_0BAD;
    req_write_i = ~wr;
  endtask

  initial begin
    RST = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0; req_wdata_i = '0;
    rsp_ready_i = 1'b1; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

    @(negedge CLK); @(negedge CLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_req_ready", req_ready_o, 1);
    chk("post_rst_penable", PENABLE, 0);
    chk("post_rst_paddr", PADDR, 0);
    chk("post_rst_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);

    // write 0x8 <- 0xA5, zero wait states
    go(32'h8, 1'b1, 32'hA5);
    chk("wr_c1_psel", PSEL, 1);
    chk("wr_c1_penable", PENABLE, 0);
    chk("wr_c1_paddr", PADDR, 32'h8);
    chk("wr_c1_pwdata", PWDATA, 32'hA5);
    chk("wr_c1_pwrite", PWRITE, 1);
    chk("wr_c1_req_ready", req_ready_o, 0);
    @(negedge CLK);
    chk("wr_c2_psel_pen", {PSEL, PENABLE}, 2'b11);
    chk("wr_c2_paddr", PADDR, 32'h8);
    chk("wr_c2_pwdata", PWDATA, 32'hA5);
    @(negedge CLK);
    chk("wr_c3_rsp_valid", rsp_valid_o, 1);
    chk("wr_c3_err_to", {rsp_err_o, rsp_timeout_o}, 0);
    chk("wr_c3_rdata", rsp_rdata_o, 0);
    chk("wr_c3_psel_pen", {PSEL, PENABLE}, 0);
    @(negedge CLK);
    chk("wr_c4_rsp_valid", rsp_valid_o, 0);
    chk("wr_c4_req_ready", req_ready_o, 1);
    chk("wr_c4_paddr_hold", PADDR, 32'h8);

    // read 0x4 with three wait states
    PREADY = 1'b0;
    go(32'h4, 1'b0, 32'h0);
    chk("rd_c1_psel_pen", {PSEL, PENABLE}, 2'b10);
    for (int c = 2; c <= 5; c++) begin
      @(negedge CLK);
      chk($sformatf("rd_c%0d_penable", c), PENABLE, 1);
      chk($sformatf("rd_c%0d_rsp_valid", c), rsp_valid_o, 0);
      if (c == 5) begin
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
      end
    end
    chk("rd_pwrite", PWRITE, 0);
    @(negedge CLK);
    PRDATA = 32'h1111_1111;
    chk("rd_c6_rsp_valid", rsp_valid_o, 1);
    chk("rd_c6_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    chk("rd_c6_err", rsp_err_o, 0);
    @(negedge CLK);

    // read completing with PSLVERR
    PSLVERR = 1'b1;
    PRDATA  = 32'h1234_5678;
    go(32'hC, 1'b0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    PSLVERR = 1'b0;
    chk("slverr_rsp_valid", rsp_valid_o, 1);
    chk("slverr_err", rsp_err_o, 1);
    chk("slverr_timeout", rsp_timeout_o, 0);
    chk("slverr_rdata", rsp_rdata_o, 32'h1234_5678);
    @(negedge CLK);

    // timeout with PREADY held low
    PREADY = 1'b0;
    go(32'h10, 1'b1, 32'h55);
    for (int c = 2; c <= 17; c++) begin
      @(negedge CLK);
      chk($sformatf("to_c%0d_psel_pen_valid", c), {PSEL, PENABLE, rsp_valid_o}, 3'b110);
    end
    @(negedge CLK);
    chk("to_c18_psel_pen", {PSEL, PENABLE}, 0);
    chk("to_c18_rsp_valid", rsp_valid_o, 1);
    chk("to_c18_err_to", {rsp_err_o, rsp_timeout_o}, 2'b11);
    chk("to_c18_rdata", rsp_rdata_o, 0);
    PREADY = 1'b1;
    PRDATA = 32'h77;
    @(negedge CLK);
    go(32'h20, 1'b0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("after_to_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b100);
    chk("after_to_rdata", rsp_rdata_o, 32'h77);
    @(negedge CLK);

    // PREADY arrives in the same cycle the timeout would fire
    PREADY = 1'b0;
    PRDATA = 32'hABC;
    go(32'h14, 1'b0, 32'h0);
    for (int c = 2; c <= 17; c++) @(negedge CLK);
    chk("edge_c17_rsp_valid", rsp_valid_o, 0);
    PREADY = 1'b1;
    @(negedge CLK);
    chk("edge_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b100);
    chk("edge_rdata", rsp_rdata_o, 32'hABC);
    @(negedge CLK);

    // response back-pressure with a command already waiting
    rsp_ready_i = 1'b0;
    PRDATA = 32'h3C;
    go(32'h24, 1'b0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    PRDATA = 32'hFFFF_0000;
    req_valid_i = 1'b1; req_addr_i = 32'h28; req_write_i = 1'b1; req_wdata_i = 32'h5A;
    for (int c = 3; c <= 7; c++) begin
      chk($sformatf("bp_c%0d_valid", c), rsp_valid_o, 1);
      chk($sformatf("bp_c%0d_rdata", c), rsp_rdata_o, 32'h3C);
      chk($sformatf("bp_c%0d_ready_psel", c), {req_ready_o, PSEL}, 0);
      if (c < 7) @(negedge CLK);
    end
    rsp_ready_i = 1'b1;
    @(negedge CLK);
    chk("bp_c8_req_ready", req_ready_o, 1);
    chk("bp_c8_psel", PSEL, 0);
    @(negedge CLK);
    req_valid_i = 1'b0;
    chk("bp_c9_psel", PSEL, 1);
    chk("bp_c9_paddr", PADDR, 32'h28);
    @(negedge CLK);
    @(negedge CLK);
    chk("bp_c11_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
    chk("bp_c11_rdata", rsp_rdata_o, 0);
    @(negedge CLK);

    // asynchronous reset in the middle of ACCESS
    PREADY = 1'b0;
    go(32'h30, 1'b1, 32'h99);
    @(negedge CLK);
    chk("rstmid_in_access", {PSEL, PENABLE}, 2'b11);
    #2 RST = 1'b1;
    #1;
    chk("rstmid_psel_pen", {PSEL, PENABLE}, 0);
    chk("rstmid_paddr", PADDR, 0);
    chk("rstmid_pwdata_pwrite", {PWDATA, PWRITE}, 0);
    chk("rstmid_rsp_valid", rsp_valid_o, 0);
    PREADY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rstmid_req_ready", req_ready_o, 1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rstmid_quiet%0d", c), {rsp_valid_o, PSEL}, 0);
      @(negedge CLK);
    end
    go(32'h40, 1'b1, 32'h1);
    @(negedge CLK);
    @(negedge CLK);
    chk("rstmid_next_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b100);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
